// File: rtl/comm_master_nb.sv
// UART command master: sends a CMD_BYTES command MSB byte first, then assembles a RESP_BYTES response.
// Optional response timeout enabled by defining COMM_TIMEOUT_EN.
module comm_master_nb #(
  parameter int unsigned CMD_BYTES      = 2,
  parameter int unsigned RESP_BYTES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned BAUD_DIV       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    snd_cmd,
  input  logic [8*CMD_BYTES-1:0]  cmd,
  input  logic                    RX,
  output logic                    TX,
  output logic                    cmd_cmplt,
  output logic [8*RESP_BYTES-1:0] resp,
  output logic                    resp_cmplt,
  output logic                    busy,
  output logic                    timeout
);

  localparam int unsigned CMD_W  = 8 * CMD_BYTES;
  localparam int unsigned RESP_W = 8 * RESP_BYTES;
  localparam int unsigned MAX_B  = (CMD_BYTES > RESP_BYTES) ? CMD_BYTES : RESP_BYTES;
  localparam int unsigned CNT_W  = $clog2(MAX_B) + 1;
  localparam int unsigned BAUD_W = $clog2(2 * BAUD_DIV);
`ifdef COMM_TIMEOUT_EN
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {IDLE, TX_LOAD, TX_WAIT, RX_WAIT, RX_CAP} state_e;

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    shift_q, shift_d;
  logic [RESP_W-1:0]   asm_q, asm_d, resp_q, resp_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                cmd_cmplt_q, cmd_cmplt_d, resp_cmplt_q, resp_cmplt_d;
  logic                busy_q, busy_d, timeout_q, timeout_d;
  logic                trmt, clr_rdy;
`ifdef COMM_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  // uart transmitter: frame shifter idles at all-ones so bit 0 is the line level
  logic [9:0]          txs_q, txs_d;
  logic [BAUD_W-1:0]   txb_q, txb_d;
  logic [3:0]          txn_q, txn_d;
  logic                tx_done_q, tx_done_d;

  always_comb begin
    txs_d     = txs_q;
    txb_d     = txb_q;
    txn_d     = txn_q;
    tx_done_d = 1'b0;
    if (trmt) begin
      txs_d = {1'b1, shift_q[CMD_W-1 -: 8], 1'b0};
      txb_d = '0;
      txn_d = 4'd10;
    end else if (txn_q != 4'd0) begin
      if (txb_q == BAUD_W'(BAUD_DIV - 1)) begin
        txb_d     = '0;
        txs_d     = {1'b1, txs_q[9:1]};
        txn_d     = txn_q - 4'd1;
        tx_done_d = (txn_q == 4'd1);
      end else begin
        txb_d = txb_q + BAUD_W'(1);
      end
    end
  end

  // uart receiver: samples mid-bit, rdy set at the stop-bit sample
  logic                rxs1_q, rxs2_q, rx_act_q, rx_act_d, rdy_q, rdy_d;
  logic [BAUD_W-1:0]   rxb_q, rxb_d;
  logic [3:0]          rxn_q, rxn_d;
  logic [7:0]          rxd_q, rxd_d;

  always_comb begin
    rx_act_d = rx_act_q;
    rxb_d    = rxb_q;
    rxn_d    = rxn_q;
    rxd_d    = rxd_q;
    rdy_d    = rdy_q & ~clr_rdy;
    if (!rx_act_q) begin
      if (!rxs2_q) begin
        rx_act_d = 1'b1;
        rxb_d    = BAUD_W'(BAUD_DIV + BAUD_DIV / 2 - 1);
        rxn_d    = 4'd0;
      end
    end else if (rxb_q != '0) begin
      rxb_d = rxb_q - BAUD_W'(1);
    end else begin
      rxb_d = BAUD_W'(BAUD_DIV - 1);
      rxn_d = rxn_q + 4'd1;
      if (rxn_q == 4'd8) begin
        rx_act_d = 1'b0;
        rdy_d    = 1'b1;
      end else begin
        rxd_d = {rxs2_q, rxd_q[7:1]};
      end
    end
  end

  // command/response sequencing
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    asm_d        = asm_q;
    resp_d       = resp_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    cmd_cmplt_d  = 1'b0;
    resp_cmplt_d = 1'b0;
    timeout_d    = 1'b0;
    trmt         = 1'b0;
    clr_rdy      = 1'b0;
`ifdef COMM_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        clr_rdy = rdy_q;
        if (snd_cmd) begin
          shift_d  = cmd;
          tx_cnt_d = '0;
          state_d  = TX_LOAD;
        end
      end
      TX_LOAD: begin
        clr_rdy = rdy_q;
        trmt    = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        clr_rdy = rdy_q;
        if (tx_done_q) begin
          shift_d  = shift_q << 8;
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == CNT_W'(CMD_BYTES - 1)) begin
            cmd_cmplt_d = 1'b1;
            rx_cnt_d    = '0;
            state_d     = RX_WAIT;
`ifdef COMM_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end else begin
            state_d = TX_LOAD;
          end
        end
      end
      RX_WAIT: begin
        if (rdy_q) begin
          state_d = RX_CAP;
`ifdef COMM_TIMEOUT_EN
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
`endif
        end
      end
      RX_CAP: begin
        clr_rdy  = 1'b1;
        asm_d    = RESP_W'({asm_q, rxd_q});
        rx_cnt_d = rx_cnt_q + CNT_W'(1);
`ifdef COMM_TIMEOUT_EN
        tmo_d    = '0;
`endif
        if (rx_cnt_q == CNT_W'(RESP_BYTES - 1)) begin
          resp_d       = asm_d;
          resp_cmplt_d = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RX_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      asm_q        <= '0;
      resp_q       <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      cmd_cmplt_q  <= 1'b0;
      resp_cmplt_q <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      txs_q        <= '1;
      txb_q        <= '0;
      txn_q        <= '0;
      tx_done_q    <= 1'b0;
      rxs1_q       <= 1'b1;
      rxs2_q       <= 1'b1;
      rx_act_q     <= 1'b0;
      rxb_q        <= '0;
      rxn_q        <= '0;
      rxd_q        <= '0;
      rdy_q        <= 1'b0;
`ifdef COMM_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      asm_q        <= asm_d;
      resp_q       <= resp_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      cmd_cmplt_q  <= cmd_cmplt_d;
      resp_cmplt_q <= resp_cmplt_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      txs_q        <= txs_d;
      txb_q        <= txb_d;
      txn_q        <= txn_d;
      tx_done_q    <= tx_done_d;
      rxs1_q       <= RX;
      rxs2_q       <= rxs1_q;
      rx_act_q     <= rx_act_d;
      rxb_q        <= rxb_d;
      rxn_q        <= rxn_d;
      rxd_q        <= rxd_d;
      rdy_q        <= rdy_d;
`ifdef COMM_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign TX         = txs_q[0];
  assign cmd_cmplt  = cmd_cmplt_q;
  assign resp       = resp_q;
  assign resp_cmplt = resp_cmplt_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;

endmodule
